dbscan_window_collector: RTL and testbench
==========================================

Name: dbscan_window_collector

Overview:
- Receiving end of the sorting-chain control.
- Consumes the per-cycle distance stream produced while the chain enable pattern walks. Counts neighbours within epsilon and tracks the minimum distance.
- When the single-cycle "final" pulse closes a DBSCAN cycle, the window result is frozen into an output register. It is then presented to the downstream clustering logic over a valid/ready handshake.

Parameters:
- N, 1000, max samples per DBSCAN window (matches chain length / final period)
- DW, 16, distance sample width (unsigned)
- CW, 10, neighbour/sample counter width; must satisfy 2^CW-1 >= N
- EPS, 16'd256, epsilon threshold, same width as DW
- MIN_PTS, 10'd8, core-point threshold, same width as CW

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- diff_valid  in  1  diff_in carries a valid distance this cycle
- diff_in  in  DW  unsigned distance sample
- final  in  1  single-cycle pulse ending the current window
- out_ready  in  1  downstream accepts result
- out_valid  out  1  result register holds an unconsumed result
- neighbour_count  out  CW  samples with diff_in <= EPS in the closed window
- sample_count  out  CW  total valid samples in the closed window
- min_diff  out  DW  smallest diff_in in the closed window
- is_core  out  1  neighbour_count >= MIN_PTS
- overrun  out  1  sticky: a window result was dropped

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - All outputs 0, including min_diff = 0.
  - Internal accumulators: counts 0, running minimum all-ones.
  - Output FSM state EMPTY.
- Accumulation, each cycle with diff_valid = 1:
  - sample counter += 1.
  - neighbour counter += 1 if diff_in <= EPS (inclusive compare).
  - running minimum = min(running minimum, diff_in).
- Both counters saturate at 2^CW-1; no wrap.
- Window close, cycle with final = 1:
  - If diff_valid is also 1, that sample is included in the closing result.
  - The closing result is the accumulator values after this cycle's update.
  - Next cycle the accumulators restart at zero-state (counts 0, min all-ones). A sample arriving the cycle after final belongs to the new window.
- Empty window (final with no samples since the last close): result is count 0, min_diff all-ones, is_core = (MIN_PTS == 0).
- Latency: final in cycle t gives out_valid = 1 in cycle t+1, with result fields valid in the same cycle.
- Output FSM, state EMPTY:
  - final: load the result register, go to FULL.
- Output FSM, state FULL:
  - out_valid = 1; result fields are held stable until transfer.
  - Transfer happens when out_valid && out_ready.
  - Transfer without final: go to EMPTY, out_valid = 0 next cycle. Result fields keep their last value.
  - Transfer and final in the same cycle: load the new result, stay FULL, out_valid stays 1.
  - final without transfer: the new result is dropped, the old result is held, overrun set to 1.
- overrun clears only on reset.
- is_core is computed from the saturated neighbour count at load time and registered with the other fields.
- Reset asserted mid-window or while FULL: accumulators, result register and FSM return to reset values next cycle. A final coincident with reset is ignored.
- diff_in is ignored when diff_valid = 0.
- final with no prior reset release behaves the same as any other final.

Decomposition:
- Shared package dbscan_pkg holds:
  - Default N, DW, CW, EPS, MIN_PTS constants.
  - Output state encoding (EMPTY = 1'b0, FULL = 1'b1).
  - A saturating-increment helper function.
- One sub-module, dbscan_window_accum:
  - Holds the counters and running minimum.
  - Inputs: diff_valid, diff_in, clear-on-final.
  - Outputs: next-state accumulator values for the load.
- The top-level module holds the output register, the handshake FSM and overrun.

Test Plan:
- Reset, then diffs 100, 300, 256, 50, 900 on consecutive cycles, final with the last sample, out_ready = 1. Expect one cycle later: out_valid = 1, neighbour_count = 3, sample_count = 5, min_diff = 50, is_core = 0. out_valid drops the following cycle.
- Ten diffs of 10, final, out_ready = 0 for 5 cycles. Expect out_valid held with neighbour_count = 10, is_core = 1 and fields stable until out_ready = 1. Then EMPTY.
- Result pending (out_ready = 0), second window of 3 samples, final. Expect overrun = 1 and the first result unchanged. After reset, overrun = 0.
- Result pending, out_ready = 1 in the same cycle as a second final. Expect out_valid to stay 1 and the fields to update to the second window with no overrun.
- final with no samples. Expect neighbour_count = 0, sample_count = 0, min_diff = 16'hFFFF, is_core = 0.
- N = 1000 window with all diffs = 0 and final on the last sample. Expect neighbour_count = 1000, no saturation. Then 1100 samples in one window: sample_count = 1023 (saturated). Then reset mid-window: next window counts from 0.

Source files
------------

// File: rtl/dbscan_pkg.sv
// Shared defaults, output-state encoding and saturating increment for the DBSCAN window collector.
// No logic of its own; imported by the accumulator and the collector top.
// Backpressure: n/a.
package dbscan_pkg;

    localparam int              N_DEF       = 1000;
    localparam int              DW_DEF      = 16;
    localparam int              CW_DEF      = 10;
    localparam logic [15:0]     EPS_DEF     = 16'd256;
    localparam logic [9:0]      MIN_PTS_DEF = 10'd8;

    localparam logic OUT_EMPTY = 1'b0;
    localparam logic OUT_FULL  = 1'b1;

    // Width-agnostic: callers widen to 32 bits and truncate the result back.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        if (value >= max_value)
            return max_value;
        return value + 32'd1;
    endfunction

endpackage

// File: rtl/dbscan_window_accum.sv
// Per-window accumulator: saturating sample/neighbour counts and running minimum distance.
// Latency: next-state values are combinational from the current sample; state updates every cycle.
// Backpressure: none, the distance stream is accepted unconditionally.
module dbscan_window_accum
    import dbscan_pkg::*;
#(
    parameter int            DW  = DW_DEF,
    parameter int            CW  = CW_DEF,
    parameter logic [DW-1:0] EPS = EPS_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          diff_valid,
    input  logic [DW-1:0] diff_in,
    input  logic          clear,
    output logic [CW-1:0] nbr_next,
    output logic [CW-1:0] cnt_next,
    output logic [DW-1:0] min_next
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] nbr_cnt;
    logic [CW-1:0] smp_cnt;
    logic [DW-1:0] run_min;

    always_comb begin
        nbr_next = nbr_cnt;
        cnt_next = smp_cnt;
        min_next = run_min;
        if (diff_valid) begin
            cnt_next = CW'(sat_inc(32'(smp_cnt), 32'(CNT_MAX)));
            if (diff_in <= EPS)
                nbr_next = CW'(sat_inc(32'(nbr_cnt), 32'(CNT_MAX)));
            if (diff_in < run_min)
                min_next = diff_in;
        end
    end

    // The closing cycle's update is consumed by the result register; state restarts empty.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            nbr_cnt <= '0;
            smp_cnt <= '0;
            run_min <= '1;
        end else begin
            nbr_cnt <= nbr_next;
            smp_cnt <= cnt_next;
            run_min <= min_next;
        end
    end

endmodule

// File: rtl/dbscan_window_collector.sv
// Collects per-window DBSCAN neighbour statistics and presents them as one registered result.
// Latency: final_pulse in cycle t -> out_valid in cycle t+1.
// Backpressure: one result slot; a window closing while the slot is held and not drained is dropped and flags overrun.
module dbscan_window_collector
    import dbscan_pkg::*;
#(
    parameter int            N       = N_DEF,
    parameter int            DW      = DW_DEF,
    parameter int            CW      = CW_DEF,
    parameter logic [DW-1:0] EPS     = EPS_DEF,
    parameter logic [CW-1:0] MIN_PTS = MIN_PTS_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          diff_valid,
    input  logic [DW-1:0] diff_in,
    // Window-close strobe; "final" itself is a reserved word.
    input  logic          final_pulse,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [CW-1:0] neighbour_count,
    output logic [CW-1:0] sample_count,
    output logic [DW-1:0] min_diff,
    output logic          is_core,
    output logic          overrun
);

    if (N > (1 << CW) - 1) begin : g_cw_too_narrow
        $error("CW too narrow for N samples per window");
    end

    typedef struct packed {
        logic [CW-1:0] nbr;
        logic [CW-1:0] cnt;
        logic [DW-1:0] mn;
        logic          core;
    } result_t;

    logic          state;
    result_t       res;
    result_t       res_next;
    logic [CW-1:0] nbr_next;
    logic [CW-1:0] cnt_next;
    logic [DW-1:0] min_next;

    dbscan_window_accum #(
        .DW  (DW),
        .CW  (CW),
        .EPS (EPS)
    ) u_accum (
        .clk        (clk),
        .reset      (reset),
        .diff_valid (diff_valid),
        .diff_in    (diff_in),
        .clear      (final_pulse),
        .nbr_next   (nbr_next),
        .cnt_next   (cnt_next),
        .min_next   (min_next)
    );

    assign res_next = '{nbr: nbr_next, cnt: cnt_next, mn: min_next, core: (nbr_next >= MIN_PTS)};

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= OUT_EMPTY;
            res     <= '0;
            overrun <= 1'b0;
        end else begin
            case (state)
                OUT_EMPTY: begin
                    if (final_pulse) begin
                        res   <= res_next;
                        state <= OUT_FULL;
                    end
                end
                default: begin
                    if (out_ready) begin
                        if (final_pulse)
                            res <= res_next;
                        else
                            state <= OUT_EMPTY;
                    end else if (final_pulse) begin
                        overrun <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign out_valid       = (state == OUT_FULL);
    assign neighbour_count = res.nbr;
    assign sample_count    = res.cnt;
    assign min_diff        = res.mn;
    assign is_core         = res.core;

endmodule

// File: tb/tb_dbscan_window_collector.sv
// Directed bench for dbscan_window_collector: expected results queued at stimulus, popped by a monitor on each transfer.
module tb_dbscan_window_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        diff_valid;
    logic [15:0] diff_in;
    logic        final_pulse;
    logic        out_ready;
    logic        out_valid;
    logic [9:0]  neighbour_count;
    logic [9:0]  sample_count;
    logic [15:0] min_diff;
    logic        is_core;
    logic        overrun;

    typedef struct {
        int nbr;
        int cnt;
        int mn;
        int core;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    dbscan_window_collector dut (
        .clk             (clk),
        .reset           (reset),
        .diff_valid      (diff_valid),
        .diff_in         (diff_in),
        .final_pulse     (final_pulse),
        .out_ready       (out_ready),
        .out_valid       (out_valid),
        .neighbour_count (neighbour_count),
        .sample_count    (sample_count),
        .min_diff        (min_diff),
        .is_core         (is_core),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic void push(input int n, input int c, input int m, input int k);
        exp_t e;
        e.nbr  = n;
        e.cnt  = c;
        e.mn   = m;
        e.core = k;
        q.push_back(e);
    endfunction

    // Inputs apply at the next rising edge; returns 1 ns after it.
    task automatic cyc(input logic v, input logic [15:0] d, input logic f);
        diff_valid  = v;
        diff_in     = d;
        final_pulse = f;
        @(posedge clk);
        #1;
        diff_valid  = 1'b0;
        diff_in     = 16'd0;
        final_pulse = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 16'd0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result actual=nbr%0d/cnt%0d expected=no result", neighbour_count, sample_count);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("mon_neighbour_count", int'(neighbour_count), e.nbr);
                chk("mon_sample_count", int'(sample_count), e.cnt);
                chk("mon_min_diff", int'(min_diff), e.mn);
                chk("mon_is_core", int'(is_core), e.core);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        diff_valid  = 1'b0;
        diff_in     = 16'd0;
        final_pulse = 1'b0;
        out_ready   = 1'b1;
        idle(3);
        reset = 1'b0;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_neighbour_count", int'(neighbour_count), 0);
        chk("rst_sample_count", int'(sample_count), 0);
        chk("rst_min_diff", int'(min_diff), 0);
        chk("rst_is_core", int'(is_core), 0);
        chk("rst_overrun", int'(overrun), 0);

        // Mixed window, inclusive epsilon at 256
        cyc(1'b1, 16'd100, 1'b0);
        cyc(1'b1, 16'd300, 1'b0);
        cyc(1'b1, 16'd256, 1'b0);
        cyc(1'b1, 16'd50, 1'b0);
        cyc(1'b1, 16'd900, 1'b1);
        push(3, 5, 50, 0);
        chk("t1_valid_latency", int'(out_valid), 1);
        idle(1);
        chk("t1_valid_drop", int'(out_valid), 0);

        // Core window held under backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) cyc(1'b1, 16'd10, 1'b0);
        cyc(1'b1, 16'd10, 1'b1);
        push(10, 10, 10, 1);
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", int'(out_valid), 1);
            chk("t2_hold_nbr", int'(neighbour_count), 10);
            chk("t2_hold_core", int'(is_core), 1);
            idle(1);
        end
        out_ready = 1'b1;
        idle(1);
        chk("t2_empty", int'(out_valid), 0);
        chk("t2_fields_kept", int'(sample_count), 10);

        // Second window while first still pending -> dropped
        out_ready = 1'b0;
        cyc(1'b1, 16'd5, 1'b0);
        cyc(1'b1, 16'd7, 1'b1);
        push(2, 2, 5, 0);
        cyc(1'b1, 16'd400, 1'b0);
        cyc(1'b1, 16'd1, 1'b0);
        cyc(1'b1, 16'd2, 1'b1);
        chk("t3_overrun", int'(overrun), 1);
        chk("t3_old_cnt", int'(sample_count), 2);
        chk("t3_old_min", int'(min_diff), 5);
        chk("t3_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        idle(1);
        chk("t3_drained", int'(out_valid), 0);
        chk("t3_overrun_sticky", int'(overrun), 1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("t3_overrun_reset", int'(overrun), 0);
        chk("t3_min_reset", int'(min_diff), 0);

        // Transfer and final in the same cycle
        out_ready = 1'b0;
        cyc(1'b1, 16'd20, 1'b1);
        push(1, 1, 20, 0);
        cyc(1'b1, 16'd300, 1'b0);
        out_ready = 1'b1;
        cyc(1'b1, 16'd500, 1'b1);
        push(0, 2, 300, 0);
        chk("t4_valid_stays", int'(out_valid), 1);
        chk("t4_new_cnt", int'(sample_count), 2);
        chk("t4_no_overrun", int'(overrun), 0);
        idle(1);
        chk("t4_drained", int'(out_valid), 0);

        // Empty window
        cyc(1'b0, 16'd0, 1'b1);
        push(0, 0, 16'hFFFF, 0);
        idle(1);

        // Full-length window, then saturation
        for (int i = 0; i < 999; i++) cyc(1'b1, 16'd0, 1'b0);
        cyc(1'b1, 16'd0, 1'b1);
        push(1000, 1000, 0, 1);
        for (int i = 0; i < 1099; i++) cyc(1'b1, 16'd0, 1'b0);
        cyc(1'b1, 16'd0, 1'b1);
        push(1023, 1023, 0, 1);
        idle(1);

        // Reset mid-window discards partial accumulation
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'd0, 1'b0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("t6_reset_valid", int'(out_valid), 0);
        cyc(1'b1, 16'd600, 1'b0);
        cyc(1'b1, 16'd600, 1'b0);
        cyc(1'b1, 16'd600, 1'b1);
        push(0, 3, 600, 0);
        idle(3);

        chk("drain_queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
